axi_rr_arbiter_n: RTL and testbench

- N-master round-robin arbiter for the shared AXI slave port.
- Grants one master per transaction and holds the grant, with no re-arbitration, until that transaction's response handshake completes.
- Generalises the two-master arbiter to NUM_MASTERS, with a registered one-hot grant, a binary grant ID, write-over-read priority within a master, and burst-aware read release on RLAST.
- Sits between master AW/AR valid lines and the address/data mux select.

---
 rtl/axi_rr_arbiter_n.sv | 137 +++++++++++++
 tb/tb_axi_rr_arbiter_n.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rr_arbiter_n.sv
// Round-robin arbiter that grants one of NUM_MASTERS AXI masters per transaction.
// Define ARB_TIMEOUT_EN to add a response watchdog that drives timeout_err.
module axi_rr_arbiter_n #(
  parameter int NUM_MASTERS    = 4,
  parameter int ID_W           = $clog2(NUM_MASTERS),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] awvalid,
  input  logic [NUM_MASTERS-1:0] arvalid,
  input  logic                   awready,
  input  logic                   arready,
  input  logic                   bvalid,
  input  logic                   bready,
  input  logic                   rvalid,
  input  logic                   rready,
  input  logic                   rlast,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [ID_W-1:0]        gnt_id,
  output logic                   gnt_write,
  output logic                   busy,
  output logic                   timeout_err
);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA} state_t;

  state_t                 state_reg;
  logic [ID_W-1:0]        ptr_reg;
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] below_ptr;
  logic [NUM_MASTERS-1:0] masked_req;
  logic [ID_W-1:0]        win_idx;
  logic [ID_W-1:0]        ptr_next;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("axi_rr_arbiter_n: illegal parameter value");
  end

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_req
    assign req[gi]        = awvalid[gi] | arvalid[gi];
    assign below_ptr[gi]  = (gi < int'(ptr_reg));
    assign masked_req[gi] = req[gi] & ~below_ptr[gi];
  end

  function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_MASTERS-1:0] v);
    lowest_set = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = ID_W'(i);
    end
  endfunction

  // Requests at or above the pointer win first; otherwise wrap to the lowest request.
  always_comb begin
    win_idx  = (|masked_req) ? lowest_set(masked_req) : lowest_set(req);
    ptr_next = (win_idx == ID_W'(NUM_MASTERS - 1)) ? '0 : win_idx + ID_W'(1);
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_reg;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_write <= 1'b0;
      busy      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      to_cnt_reg  <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req) begin
            gnt     <= NUM_MASTERS'(1) << win_idx;
            gnt_id  <= win_idx;
            busy    <= 1'b1;
            ptr_reg <= ptr_next;
            if (awvalid[win_idx]) begin
              state_reg <= WR_ADDR;
              gnt_write <= 1'b1;
            end else begin
              state_reg <= RD_ADDR;
              gnt_write <= 1'b0;
            end
          end
        end
        WR_ADDR: if (awvalid[gnt_id] && awready) state_reg <= WR_RESP;
        RD_ADDR: if (arvalid[gnt_id] && arready) state_reg <= RD_DATA;
        WR_RESP: begin
          if (bvalid && bready) begin
            state_reg <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_write <= 1'b0;
            busy      <= 1'b0;
          end
        end
        RD_DATA: begin
          if (rvalid && rready && rlast) begin
            state_reg <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_write <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
`ifdef ARB_TIMEOUT_EN
      // Counter spans the whole transaction; expiry overrides any transition above.
      timeout_err <= 1'b0;
      if (state_reg == IDLE) begin
        to_cnt_reg <= '0;
      end else if (to_cnt_reg == TO_W'(TIMEOUT_CYCLES)) begin
        state_reg   <= IDLE;
        gnt         <= '0;
        gnt_id      <= '0;
        gnt_write   <= 1'b0;
        busy        <= 1'b0;
        timeout_err <= 1'b1;
        to_cnt_reg  <= '0;
      end else begin
        to_cnt_reg <= to_cnt_reg + TO_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi_rr_arbiter_n.sv
// Scoreboard bench for axi_rr_arbiter_n: stimulus pushes expected grants, a monitor pops and compares.
`timescale 1ns/1ps
module tb_axi_rr_arbiter_n;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] awvalid = '0;
  logic [N-1:0] arvalid = '0;
  logic awready = 1'b0, arready = 1'b0;
  logic bvalid = 1'b0, bready = 1'b0;
  logic rvalid = 1'b0, rready = 1'b0, rlast = 1'b0;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic gnt_write, busy, timeout_err;

  always #5 clk = ~clk;

  axi_rr_arbiter_n #(.NUM_MASTERS(N), .ID_W(IDW)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .arvalid(arvalid),
    .awready(awready), .arready(arready),
    .bvalid(bvalid), .bready(bready),
    .rvalid(rvalid), .rready(rready), .rlast(rlast),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_write(gnt_write),
    .busy(busy), .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [N-1:0]   gnt;
    logic [IDW-1:0] id;
    logic           wr;
  } grant_t;

  grant_t exp_q[$];
  int     model_ptr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference: first requester at or after the pointer, walking around the ring.
  function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic int push_expect(input logic [N-1:0] aw, input logic [N-1:0] ar);
    int w;
    grant_t g;
    w = rr_pick(aw | ar, model_ptr);
    if (w < 0) return -1;
    g.gnt    = '0;
    g.gnt[w] = 1'b1;
    g.id     = IDW'(w);
    g.wr     = aw[w];
    exp_q.push_back(g);
    model_ptr = (w + 1) % N;
    $display("txn: req aw=%b ar=%b -> expect master %0d %s", aw, ar, w, aw[w] ? "write" : "read");
    return w;
  endfunction

  function automatic logic [N-1:0] rnd_mask();
    return N'($urandom);
  endfunction

  initial begin : monitor
    grant_t cur;
    logic   prev_busy;
    prev_busy = 1'b0;
    cur       = '0;
    forever begin
      @(negedge clk);
      check("timeout_err_low", 32'(timeout_err), 0);
      if (rst) begin
        prev_busy = 1'b0;
        continue;
      end
      if (busy && !prev_busy) begin
        if (exp_q.size() == 0) begin
          check("spurious_grant", 32'(busy), 0);
          cur = '0;
        end else begin
          cur = exp_q.pop_front();
          check("grant_onehot", 32'(gnt), 32'(cur.gnt));
          check("grant_id", 32'(gnt_id), 32'(cur.id));
          check("grant_write", 32'(gnt_write), 32'(cur.wr));
        end
      end else if (busy) begin
        check("grant_stable", 32'({gnt, gnt_id, gnt_write}), 32'({cur.gnt, cur.id, cur.wr}));
      end else begin
        check("idle_zero", 32'({gnt, gnt_id, gnt_write}), 0);
      end
      prev_busy = busy;
    end
  end

  // One arbitration round, entered and left on a negedge with the arbiter idle.
  task automatic do_txn(input logic [N-1:0] aw, input logic [N-1:0] ar, input int beats);
    int w;
    logic wr;
    logic [N-1:0] bit_w;
    awvalid = aw;
    arvalid = ar;
    w = push_expect(aw, ar);
    if (w < 0) begin
      @(negedge clk);
      check("no_req_idle", 32'(busy), 0);
      return;
    end
    wr       = aw[w];
    bit_w    = '0;
    bit_w[w] = 1'b1;
    @(negedge clk);
    check("grant_latency", 32'(busy), 1);
    repeat ($urandom_range(0, 2)) begin
      awvalid = rnd_mask() & ~bit_w;
      arvalid = rnd_mask() & ~bit_w;
      awready = 1'($urandom_range(0, 1));
      arready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("addr_wait_hold", 32'(busy), 1);
    end
    if (wr) begin
      awvalid = rnd_mask() | bit_w;
      awready = 1'b1;
      arready = 1'b0;
    end else begin
      arvalid = rnd_mask() | bit_w;
      arready = 1'b1;
      awready = 1'b0;
    end
    @(negedge clk);
    check("addr_done_hold", 32'(busy), 1);
    awready = 1'b0;
    arready = 1'b0;
    awvalid = rnd_mask() & ~bit_w;
    arvalid = rnd_mask() & ~bit_w;
    if (wr) begin
      repeat ($urandom_range(0, 2)) begin
        bvalid = 1'($urandom_range(0, 1));
        bready = ~bvalid;
        @(negedge clk);
        check("bresp_wait_hold", 32'(busy), 1);
      end
      bvalid = 1'b1;
      bready = 1'b1;
      @(negedge clk);
      check("bresp_release", 32'(busy), 0);
      bvalid = 1'b0;
      bready = 1'b0;
    end else begin
      for (int b = 1; b <= beats; b++) begin
        rlast = (b == beats);
        if ($urandom_range(0, 1) == 1) begin
          rvalid = 1'b1;
          rready = 1'b0;
          @(negedge clk);
          check("rdata_stall_hold", 32'(busy), 1);
        end
        rvalid = 1'b1;
        rready = 1'b1;
        @(negedge clk);
        if (b == beats) check("rlast_release", 32'(busy), 0);
        else            check("rbeat_hold", 32'(busy), 1);
      end
      rvalid = 1'b0;
      rready = 1'b0;
      rlast  = 1'b0;
    end
  endtask

  initial begin : stimulus
    logic [N-1:0] aw, ar;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("reset_idle", 32'({busy, gnt, gnt_id}), 0);
    end

    // All masters writing: grants rotate 0,1,2,3,0.
    repeat (5) do_txn('1, '0, 1);
    // Write wins over read in the same master, then a 4-beat read burst.
    do_txn(4'b0100, 4'b0100, 1);
    do_txn(4'b0000, 4'b0100, 4);
    // Lone master 1, then masters 0 and 3 with the pointer at 2.
    do_txn(4'b0010, 4'b0000, 1);
    do_txn(4'b1001, 4'b0000, 1);
    do_txn(4'b0001, 4'b0000, 1);

    repeat (200) begin
      aw = rnd_mask();
      ar = rnd_mask();
      if ($urandom_range(0, 7) == 0) begin
        aw = '0;
        ar = '0;
      end
      do_txn(aw, ar, int'($urandom_range(1, 4)));
    end

    // Reset in the middle of a read burst.
    awvalid = '0;
    arvalid = 4'b0100;
    void'(push_expect(awvalid, arvalid));
    @(negedge clk);
    check("mid_rst_grant", 32'(busy), 1);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    arvalid = '0;
    rvalid  = 1'b1;
    rready  = 1'b1;
    rlast   = 1'b0;
    repeat (2) @(negedge clk);
    rvalid = 1'b0;
    rready = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    check("mid_rst_clear", 32'({busy, gnt, gnt_id, gnt_write}), 0);
    rst       = 1'b0;
    model_ptr = 0;
    do_txn(4'b1010, 4'b0000, 1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
